// File: rtl/sauria_rst_seq_wdog.sv
// Reset sequencer and run watchdog for the SAURIA subsystem.
// Holds all reset domains low, releases them one at a time in index order,
// then watches for activity kicks while the subsystem runs.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_HOLD    | every domain held in reset, hold counter running
// ST_RELEASE | domains released in order, one every STAGGER_CYCLES
// ST_RUN     | all domains out of reset, watchdog armed when enabled
// ST_DONE    | run complete, parked until a software reset
// ST_TIMEOUT | watchdog expired; parks, or re-enters HOLD if AUTO_RERESET
module sauria_rst_seq_wdog #(
    parameter int N_DOMAINS      = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDOG_W         = 32,
    parameter bit AUTO_RERESET   = 1'b0
) (
    input  logic                 i_sauria_clk,
    input  logic                 i_sauria_rst,
    input  logic                 i_sw_rst_req,
    input  logic                 i_wdog_en,
    input  logic [WDOG_W-1:0]    i_wdog_limit,
    input  logic                 i_wdog_kick,
    input  logic                 i_done,
    input  logic                 i_clr_timeout,
    output logic [N_DOMAINS-1:0] o_domain_rstn,
    output logic                 o_ready,
    output logic                 o_done,
    output logic                 o_wdog_timeout,
    output logic [7:0]           o_timeout_cnt,
    output logic [2:0]           o_state
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int RW = $clog2(N_DOMAINS + 1);

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [SW-1:0]         stag_cnt_q, stag_cnt_d;
    logic [RW-1:0]         rel_idx_q, rel_idx_d;
    logic [WDOG_W-1:0]     wdog_cnt_q, wdog_cnt_d;
    logic [N_DOMAINS-1:0]  rstn_q, rstn_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  wdog_active;
    logic                  tmo_set;

    // Register every piece of state; outputs come straight from these flops.
    always_ff @(posedge i_sauria_clk) begin
        if (i_sauria_rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            rel_idx_q  <= '0;
            wdog_cnt_q <= '0;
            rstn_q     <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stag_cnt_q <= stag_cnt_d;
            rel_idx_q  <= rel_idx_d;
            wdog_cnt_q <= wdog_cnt_d;
            rstn_q     <= rstn_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Next-state, counter and output decode; software reset overrides all transitions.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stag_cnt_d  = stag_cnt_q;
        rel_idx_d   = rel_idx_q;
        wdog_cnt_d  = wdog_cnt_q;
        rstn_d      = rstn_q;
        tmo_set     = 1'b0;
        wdog_active = i_wdog_en && (i_wdog_limit != '0);

        if (i_sw_rst_req) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            stag_cnt_d = '0;
            rel_idx_d  = '0;
            wdog_cnt_d = '0;
            rstn_d     = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rstn_d = '0;
                    if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                        state_d    = ST_RELEASE;
                        hold_cnt_d = '0;
                        stag_cnt_d = '0;
                        rel_idx_d  = RW'(1);
                        rstn_d[0]  = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (rel_idx_q == RW'(N_DOMAINS)) begin
                        state_d    = ST_RUN;
                        wdog_cnt_d = '0;
                    end else if (stag_cnt_q == SW'(STAGGER_CYCLES - 1)) begin
                        stag_cnt_d = '0;
                        rel_idx_d  = rel_idx_q + RW'(1);
                        for (int k = 0; k < N_DOMAINS; k++) begin
                            if (rel_idx_q == RW'(k)) rstn_d[k] = 1'b1;
                        end
                    end else begin
                        stag_cnt_d = stag_cnt_q + SW'(1);
                    end
                end
                ST_RUN: begin
                    if (i_done) begin
                        state_d    = ST_DONE;
                        wdog_cnt_d = '0;
                    end else if (!wdog_active || i_wdog_kick) begin
                        wdog_cnt_d = '0;
                    end else if (wdog_cnt_q >= i_wdog_limit - WDOG_W'(1)) begin
                        state_d    = ST_TIMEOUT;
                        wdog_cnt_d = '0;
                        tmo_set    = 1'b1;
                    end else begin
                        wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
                    end
                end
                ST_TIMEOUT: begin
                    if (AUTO_RERESET) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                        rel_idx_d  = '0;
                        rstn_d     = '0;
                    end
                end
                default: ;
            endcase
        end

        ready_d = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);

        tmo_d     = tmo_q;
        tmo_cnt_d = tmo_cnt_q;
        if (tmo_set) begin
            tmo_d = 1'b1;
            if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        end else if (i_clr_timeout) begin
            tmo_d = 1'b0;
        end
    end

    assign o_domain_rstn  = rstn_q;
    assign o_ready        = ready_q;
    assign o_done         = done_q;
    assign o_wdog_timeout = tmo_q;
    assign o_timeout_cnt  = tmo_cnt_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_sauria_rst_seq_wdog.sv
// Directed bench for sauria_rst_seq_wdog: a parking instance with two domains
// and an auto re-reset instance with a single domain.
module tb_sauria_rst_seq_wdog;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults, parks in TIMEOUT
    logic        rst, sw, en, kick, done_i, clr;
    logic [31:0] lim;
    logic [1:0]  rstn;
    logic        ready, done_o, tmo;
    logic [7:0]  tcnt;
    logic [2:0]  st;

    // Instance B: single domain, automatic re-reset
    logic        rst2, sw2, en2, kick2, done2_i, clr2;
    logic [31:0] lim2;
    logic [0:0]  rstn2;
    logic        ready2, done2_o, tmo2;
    logic [7:0]  tcnt2;
    logic [2:0]  st2;

    int n_cmp = 0;
    int n_bad = 0;

    sauria_rst_seq_wdog #(
        .N_DOMAINS(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .WDOG_W(32), .AUTO_RERESET(1'b0)
    ) dut_a (
        .i_sauria_clk(clk), .i_sauria_rst(rst), .i_sw_rst_req(sw), .i_wdog_en(en),
        .i_wdog_limit(lim), .i_wdog_kick(kick), .i_done(done_i), .i_clr_timeout(clr),
        .o_domain_rstn(rstn), .o_ready(ready), .o_done(done_o), .o_wdog_timeout(tmo),
        .o_timeout_cnt(tcnt), .o_state(st)
    );

    sauria_rst_seq_wdog #(
        .N_DOMAINS(1), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .WDOG_W(32), .AUTO_RERESET(1'b1)
    ) dut_b (
        .i_sauria_clk(clk), .i_sauria_rst(rst2), .i_sw_rst_req(sw2), .i_wdog_en(en2),
        .i_wdog_limit(lim2), .i_wdog_kick(kick2), .i_done(done2_i), .i_clr_timeout(clr2),
        .o_domain_rstn(rstn2), .o_ready(ready2), .o_done(done2_o), .o_wdog_timeout(tmo2),
        .o_timeout_cnt(tcnt2), .o_state(st2)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sw = 1'b0; en = 1'b0; lim = 32'd0; kick = 1'b0; done_i = 1'b0; clr = 1'b0;
        rst2 = 1'b1; sw2 = 1'b0; en2 = 1'b0; lim2 = 32'd0; kick2 = 1'b0; done2_i = 1'b0; clr2 = 1'b0;
        step(3);
        n_cmp++; if (st !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", st); end
        n_cmp++; if (rstn !== 2'b00) begin n_bad++; $display("FAIL reset_rstn: got %b want 00", rstn); end
        n_cmp++; if ({ready, done_o, tmo} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {ready, done_o, tmo}); end
        n_cmp++; if (tcnt !== 8'd0) begin n_bad++; $display("FAIL reset_tcnt: got %0d want 0", tcnt); end
        rst = 1'b0;
    endtask

    task automatic test_release;
        step(15);
        n_cmp++; if (rstn !== 2'b00 || st !== 3'd0) begin n_bad++; $display("FAIL rel_edge15: got rstn=%b st=%0d want 00/0", rstn, st); end
        step(1);
        n_cmp++; if (rstn !== 2'b01 || st !== 3'd1) begin n_bad++; $display("FAIL rel_edge16: got rstn=%b st=%0d want 01/1", rstn, st); end
        step(3);
        n_cmp++; if (rstn !== 2'b01) begin n_bad++; $display("FAIL rel_edge19: got rstn=%b want 01", rstn); end
        step(1);
        n_cmp++; if (rstn !== 2'b11 || st !== 3'd1 || ready !== 1'b0) begin n_bad++; $display("FAIL rel_edge20: got rstn=%b st=%0d rdy=%b want 11/1/0", rstn, st, ready); end
        step(1);
        n_cmp++; if (st !== 3'd2 || ready !== 1'b1) begin n_bad++; $display("FAIL rel_edge21: got st=%0d rdy=%b want 2/1", st, ready); end
    endtask

    task automatic test_wdog_timeout;
        en = 1'b1; lim = 32'd10;
        step(9);
        n_cmp++; if (st !== 3'd2 || tmo !== 1'b0) begin n_bad++; $display("FAIL wdog_pre: got st=%0d tmo=%b want 2/0", st, tmo); end
        step(1);
        n_cmp++; if (st !== 3'd4 || tmo !== 1'b1 || tcnt !== 8'd1) begin n_bad++; $display("FAIL wdog_hit: got st=%0d tmo=%b cnt=%0d want 4/1/1", st, tmo, tcnt); end
        n_cmp++; if (rstn !== 2'b11 || ready !== 1'b0) begin n_bad++; $display("FAIL wdog_hit_out: got rstn=%b rdy=%b want 11/0", rstn, ready); end
        step(5);
        n_cmp++; if (st !== 3'd4 || rstn !== 2'b11) begin n_bad++; $display("FAIL wdog_park: got st=%0d rstn=%b want 4/11", st, rstn); end
    endtask

    task automatic test_sw_rst;
        en = 1'b0;
        sw = 1'b1;
        step(5);
        n_cmp++; if (st !== 3'd0 || rstn !== 2'b00) begin n_bad++; $display("FAIL sw_level: got st=%0d rstn=%b want 0/00", st, rstn); end
        n_cmp++; if (tmo !== 1'b1 || tcnt !== 8'd1) begin n_bad++; $display("FAIL sw_sticky: got tmo=%b cnt=%0d want 1/1", tmo, tcnt); end
        sw = 1'b0;
        step(16);
        n_cmp++; if (rstn !== 2'b01 || st !== 3'd1) begin n_bad++; $display("FAIL sw_after_level: got rstn=%b st=%0d want 01/1", rstn, st); end
        sw = 1'b1;
        step(1);
        sw = 1'b0;
        n_cmp++; if (rstn !== 2'b00 || st !== 3'd0 || tmo !== 1'b1) begin n_bad++; $display("FAIL sw_pulse: got rstn=%b st=%0d tmo=%b want 00/0/1", rstn, st, tmo); end
        step(15);
        n_cmp++; if (rstn !== 2'b00) begin n_bad++; $display("FAIL sw_rep15: got rstn=%b want 00", rstn); end
        step(1);
        n_cmp++; if (rstn !== 2'b01) begin n_bad++; $display("FAIL sw_rep16: got rstn=%b want 01", rstn); end
        step(4);
        n_cmp++; if (rstn !== 2'b11) begin n_bad++; $display("FAIL sw_rep20: got rstn=%b want 11", rstn); end
        step(1);
        n_cmp++; if (st !== 3'd2 || ready !== 1'b1 || tcnt !== 8'd1) begin n_bad++; $display("FAIL sw_rep21: got st=%0d rdy=%b cnt=%0d want 2/1/1", st, ready, tcnt); end
    endtask

    task automatic test_clr;
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        n_cmp++; if (tmo !== 1'b0 || tcnt !== 8'd1 || st !== 3'd2) begin n_bad++; $display("FAIL clr: got tmo=%b cnt=%0d st=%0d want 0/1/2", tmo, tcnt, st); end
    endtask

    task automatic test_kick;
        int late;
        late = 0;
        en = 1'b1; lim = 32'd10;
        for (int i = 0; i < 99; i++) begin
            kick = ((i % 9) == 8);
            step(1);
            if (st !== 3'd2 || tmo !== 1'b0) late++;
        end
        kick = 1'b0;
        n_cmp++; if (late != 0) begin n_bad++; $display("FAIL kick_loop: got %0d bad cycles want 0", late); end
        step(9);
        kick = 1'b1;
        step(1);
        kick = 1'b0;
        n_cmp++; if (st !== 3'd2 || tmo !== 1'b0) begin n_bad++; $display("FAIL kick_vs_tmo: got st=%0d tmo=%b want 2/0", st, tmo); end
        step(9);
        n_cmp++; if (st !== 3'd2) begin n_bad++; $display("FAIL kick_cleared: got st=%0d want 2", st); end
        step(1);
        n_cmp++; if (st !== 3'd4 || tcnt !== 8'd2) begin n_bad++; $display("FAIL kick_then_tmo: got st=%0d cnt=%0d want 4/2", st, tcnt); end
    endtask

    task automatic go_run(input logic with_clr);
        en = 1'b0;
        sw = 1'b1; clr = with_clr;
        step(1);
        sw = 1'b0; clr = 1'b0;
        step(21);
        n_cmp++; if (st !== 3'd2 || ready !== 1'b1) begin n_bad++; $display("FAIL go_run: got st=%0d rdy=%b want 2/1", st, ready); end
    endtask

    task automatic test_done_vs_timeout;
        go_run(1'b1);
        n_cmp++; if (tmo !== 1'b0) begin n_bad++; $display("FAIL done_pre_tmo: got %b want 0", tmo); end
        en = 1'b1; lim = 32'd10;
        step(9);
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        n_cmp++; if (st !== 3'd3 || done_o !== 1'b1 || ready !== 1'b0) begin n_bad++; $display("FAIL done_win: got st=%0d done=%b rdy=%b want 3/1/0", st, done_o, ready); end
        n_cmp++; if (tmo !== 1'b0 || tcnt !== 8'd2) begin n_bad++; $display("FAIL done_no_tmo: got tmo=%b cnt=%0d want 0/2", tmo, tcnt); end
        step(12);
        n_cmp++; if (st !== 3'd3 || rstn !== 2'b11) begin n_bad++; $display("FAIL done_hold: got st=%0d rstn=%b want 3/11", st, rstn); end
    endtask

    task automatic test_limit_lowered;
        go_run(1'b0);
        en = 1'b1; lim = 32'd0;
        step(30);
        n_cmp++; if (st !== 3'd2 || tmo !== 1'b0) begin n_bad++; $display("FAIL limit_zero: got st=%0d tmo=%b want 2/0", st, tmo); end
        lim = 32'd10;
        step(6);
        lim = 32'd4; clr = 1'b1;
        step(1);
        clr = 1'b0;
        n_cmp++; if (st !== 3'd4 || tmo !== 1'b1 || tcnt !== 8'd3) begin n_bad++; $display("FAIL limit_lowered: got st=%0d tmo=%b cnt=%0d want 4/1/3", st, tmo, tcnt); end
    endtask

    task automatic test_auto_rereset;
        en2 = 1'b1; lim2 = 32'd3;
        rst2 = 1'b0;
        step(16);
        n_cmp++; if (st2 !== 3'd1 || rstn2 !== 1'b1) begin n_bad++; $display("FAIL auto_rel: got st=%0d rstn=%b want 1/1", st2, rstn2); end
        step(1);
        n_cmp++; if (st2 !== 3'd2 || ready2 !== 1'b1) begin n_bad++; $display("FAIL auto_n1_run: got st=%0d rdy=%b want 2/1", st2, ready2); end
        step(3);
        n_cmp++; if (st2 !== 3'd4 || tmo2 !== 1'b1 || tcnt2 !== 8'd1) begin n_bad++; $display("FAIL auto_tmo1: got st=%0d tmo=%b cnt=%0d want 4/1/1", st2, tmo2, tcnt2); end
        step(1);
        n_cmp++; if (st2 !== 3'd0 || rstn2 !== 1'b0 || ready2 !== 1'b0) begin n_bad++; $display("FAIL auto_rehold: got st=%0d rstn=%b rdy=%b want 0/0/0", st2, rstn2, ready2); end
        step(5332);
        n_cmp++; if (st2 !== 3'd2 || tcnt2 !== 8'd254) begin n_bad++; $display("FAIL auto_254: got st=%0d cnt=%0d want 2/254", st2, tcnt2); end
        step(1);
        n_cmp++; if (st2 !== 3'd4 || tcnt2 !== 8'd255) begin n_bad++; $display("FAIL auto_255: got st=%0d cnt=%0d want 4/255", st2, tcnt2); end
        step(42);
        n_cmp++; if (st2 !== 3'd4 || tcnt2 !== 8'd255 || tmo2 !== 1'b1) begin n_bad++; $display("FAIL auto_sat: got st=%0d cnt=%0d tmo=%b want 4/255/1", st2, tcnt2, tmo2); end
        clr2 = 1'b1;
        step(1);
        clr2 = 1'b0;
        n_cmp++; if (tmo2 !== 1'b0 || tcnt2 !== 8'd255 || st2 !== 3'd0) begin n_bad++; $display("FAIL auto_clr: got tmo=%b cnt=%0d st=%0d want 0/255/0", tmo2, tcnt2, st2); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_wdog_timeout();
        test_sw_rst();
        test_clr();
        test_kick();
        test_done_vs_timeout();
        test_limit_lowered();
        test_auto_rereset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
